mem_arbiter: RTL and testbench

Shares the single MEMORY port (memread/memwrite/memaddr/memwdata/memrdata) between two requesters, m0 and m1. m0 is the CORE data side; m1 is a secondary master such as IO/DMA or instruction fetch. Arbitration is round-robin, with at most one outstanding read. Writes complete in the grant cycle. Sits in top between the requesters and MEMORY.

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arbiter_rr_pick2.sv | 32 +++
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for mem_arbiter: FSM state encodings, latency counter width, grant codes.
// Also provides fallback values for the global WIDTH / ADDR_WIDTH defines.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mem_arbiter_pkg;

    typedef enum logic {
        MEM_ARB_IDLE    = 1'b0,
        MEM_ARB_RD_WAIT = 1'b1
    } arb_state_t;

    localparam int LAT_W = 3;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way picker producing a one-hot grant from req and the last winner.
// With MEM_ARB_FIXED_PRIO_EN defined, m0 always wins a conflict and last_gnt is ignored.
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

    // One-hot winner selection; on conflict the requester that did not win last time goes first.
    always_comb begin
        gnt = GNT_NONE;
        case (req)
            2'b01:   gnt = GNT_M0;
            2'b10:   gnt = GNT_M1;
            2'b11: begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                gnt = GNT_M0;
`else
                if (last_gnt) begin
                    gnt = GNT_M0;
                end else begin
                    gnt = GNT_M1;
                end
`endif
            end
            default: gnt = GNT_NONE;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between m0 and m1 with round-robin arbitration and one read in flight.
// Define MEM_ARB_FIXED_PRIO_EN to make m0 always win conflicts.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = `ADDR_WIDTH,
    parameter int DATA_W = `WIDTH,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              memread_o,
    output logic              memwrite_o,
    output logic [ADDR_W-1:0] memaddr_o,
    output logic [DATA_W-1:0] memwdata_o,
    input  logic [DATA_W-1:0] memrdata_i
);

    localparam logic [LAT_W-1:0] RD_LAT_C = LAT_W'(RD_LAT);

    arb_state_t       state_r;
    arb_state_t       state_s;
    logic [LAT_W-1:0] lat_cnt_r;
    logic             owner_r;
    logic             last_gnt_r;
    logic [1:0]       req_s;
    logic [1:0]       pick_s;
    logic [1:0]       gnt_s;
    logic             win_s;
    logic             win_we_s;
    logic             rd_done_s;

    assign req_s = {m1_req_i, m0_req_i};

    rr_pick2 u_pick (
        .req      (req_s),
        .last_gnt (last_gnt_r),
        .gnt      (pick_s)
    );

    // Next-state and grant decision; everything is held off while reset is asserted.
    always_comb begin
        state_s   = state_r;
        gnt_s     = GNT_NONE;
        win_s     = pick_s[1];
        win_we_s  = 1'b0;
        rd_done_s = 1'b0;
        if (!rst) begin
            state_s = MEM_ARB_IDLE;
        end else begin
            case (state_r)
                MEM_ARB_IDLE: begin
                    gnt_s = pick_s;
                    if (pick_s != GNT_NONE) begin
                        win_we_s = win_s ? m1_we_i : m0_we_i;
                        state_s  = win_we_s ? MEM_ARB_IDLE : MEM_ARB_RD_WAIT;
                    end else begin
                        state_s = MEM_ARB_IDLE;
                    end
                end
                MEM_ARB_RD_WAIT: begin
                    // <= also recovers from a zero count rather than wrapping for 8 cycles
                    if (lat_cnt_r <= 3'd1) begin
                        rd_done_s = 1'b1;
                        state_s   = MEM_ARB_IDLE;
                    end else begin
                        state_s = MEM_ARB_RD_WAIT;
                    end
                end
                default: state_s = MEM_ARB_IDLE;
            endcase
        end
    end

    // Memory command mux and read-return steering.
    always_comb begin
        m0_gnt_o   = gnt_s[0];
        m1_gnt_o   = gnt_s[1];
        memread_o  = 1'b0;
        memwrite_o = 1'b0;
        memaddr_o  = {ADDR_W{1'b0}};
        memwdata_o = {DATA_W{1'b0}};
        if (gnt_s != GNT_NONE) begin
            memread_o  = !win_we_s;
            memwrite_o = win_we_s;
            memaddr_o  = win_s ? m1_addr_i : m0_addr_i;
            memwdata_o = win_s ? m1_wdata_i : m0_wdata_i;
        end else begin
            memread_o  = 1'b0;
            memwrite_o = 1'b0;
        end
        m0_rvalid_o = rd_done_s & !owner_r;
        m1_rvalid_o = rd_done_s & owner_r;
        m0_rdata_o  = m0_rvalid_o ? memrdata_i : {DATA_W{1'b0}};
        m1_rdata_o  = m1_rvalid_o ? memrdata_i : {DATA_W{1'b0}};
    end

    // State, read owner, latency counter and round-robin history.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= MEM_ARB_IDLE;
            lat_cnt_r  <= 3'd0;
            owner_r    <= 1'b0;
            last_gnt_r <= 1'b1;
        end else begin
            state_r <= state_s;
            if (gnt_s != GNT_NONE) begin
                last_gnt_r <= win_s;
                if (!win_we_s) begin
                    owner_r   <= win_s;
                    lat_cnt_r <= RD_LAT_C;
                end else begin
                    owner_r   <= owner_r;
                    lat_cnt_r <= lat_cnt_r;
                end
            end else if (state_r == MEM_ARB_RD_WAIT) begin
                lat_cnt_r <= lat_cnt_r - 3'd1;
            end else begin
                lat_cnt_r <= lat_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: instance a uses RD_LAT=1, instance b uses RD_LAT=3, both fed the same requests.
// Read data is checked through a scoreboard queue; control outputs are checked cycle by cycle.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = 32'h0, m0_wdata = 32'h0, m1_addr = 32'h0, m1_wdata = 32'h0;

    logic        a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid, a_memread, a_memwrite;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_memaddr, a_memwdata, a_memrdata;
    logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid, b_memread, b_memwrite;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_memaddr, b_memwdata, b_memrdata;

    wire [5:0] a_ctl = {a_m0_gnt, a_m1_gnt, a_memread, a_memwrite, a_m0_rvalid, a_m1_rvalid};
    wire [5:0] b_ctl = {b_m0_gnt, b_m1_gnt, b_memread, b_memwrite, b_m0_rvalid, b_m1_rvalid};

    typedef struct packed {
        logic        m;
        logic [31:0] d;
    } rd_t;
    rd_t sb[$];
    rd_t e;

    int n_cmp = 0;
    int n_err = 0;

    logic        pl_we = 1'b0;
    logic [7:0]  pl_addr = 8'h0;
    logic [31:0] pl_data = 32'h0;
    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];
    logic [31:0] pipe_a;
    logic [31:0] pipe_b [0:2];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_gnt_o(a_m0_gnt), .m0_rvalid_o(a_m0_rvalid), .m0_rdata_o(a_m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_gnt_o(a_m1_gnt), .m1_rvalid_o(a_m1_rvalid), .m1_rdata_o(a_m1_rdata),
        .memread_o(a_memread), .memwrite_o(a_memwrite), .memaddr_o(a_memaddr),
        .memwdata_o(a_memwdata), .memrdata_i(a_memrdata)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) u_dut_b (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_gnt_o(b_m0_gnt), .m0_rvalid_o(b_m0_rvalid), .m0_rdata_o(b_m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_gnt_o(b_m1_gnt), .m1_rvalid_o(b_m1_rvalid), .m1_rdata_o(b_m1_rdata),
        .memread_o(b_memread), .memwrite_o(b_memwrite), .memaddr_o(b_memaddr),
        .memwdata_o(b_memwdata), .memrdata_i(b_memrdata)
    );

    // Memory models: data appears RD_LAT cycles after the read strobe, junk otherwise.
    always @(posedge clk) begin
        if (pl_we) begin
            mem_a[pl_addr] <= pl_data;
            mem_b[pl_addr] <= pl_data;
        end else begin
            if (a_memwrite) mem_a[a_memaddr[7:0]] <= a_memwdata;
            if (b_memwrite) mem_b[b_memaddr[7:0]] <= b_memwdata;
        end
        pipe_a    <= a_memread ? mem_a[a_memaddr[7:0]] : 32'hDEAD_000A;
        pipe_b[0] <= b_memread ? mem_b[b_memaddr[7:0]] : 32'hDEAD_000B;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign a_memrdata = pipe_a;
    assign b_memrdata = pipe_b[2];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        m0_req = 1'b0;
        m1_req = 1'b0;
        m0_we  = 1'b0;
        m1_we  = 1'b0;
    endtask

    task automatic do_reset();
        clear_reqs();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic preload(input logic [7:0] addr, input logic [31:0] data);
        pl_we = 1'b1; pl_addr = addr; pl_data = data;
        step();
        pl_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h14; m1_wdata = 32'h99;
        step();
        #1;
        n_cmp++;
        if (a_ctl !== 6'b000000) begin n_err++; $display("FAIL rst_ctl_a got=%b want=000000", a_ctl); end
        n_cmp++;
        if (b_ctl !== 6'b000000) begin n_err++; $display("FAIL rst_ctl_b got=%b want=000000", b_ctl); end
        n_cmp++;
        if ({a_memaddr, a_memwdata, a_m0_rdata, a_m1_rdata} !== 128'h0) begin
            n_err++; $display("FAIL rst_buses_a got=%h/%h/%h/%h want=0", a_memaddr, a_memwdata, a_m0_rdata, a_m1_rdata);
        end
        step();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (a_ctl !== 6'b101000) begin n_err++; $display("FAIL rst_first_conflict got=%b want=101000", a_ctl); end
        clear_reqs();
    endtask

    task automatic test_read();
        do_reset();
        preload(8'h10, 32'hA5A5_0001);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
        #1;
        n_cmp++;
        if (a_ctl !== 6'b101000) begin n_err++; $display("FAIL t1_gnt_ctl got=%b want=101000", a_ctl); end
        n_cmp++;
        if (a_memaddr !== 32'h10) begin n_err++; $display("FAIL t1_addr got=%h want=00000010", a_memaddr); end
        sb.push_back('{m: 1'b0, d: 32'hA5A5_0001});
        step();
        m0_req = 1'b0;
        #1;
        n_cmp++;
        if (a_ctl !== 6'b000010) begin n_err++; $display("FAIL t1_rv_ctl got=%b want=000010", a_ctl); end
        if (a_m0_rvalid && sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (e.m !== 1'b0 || a_m0_rdata !== e.d) begin n_err++; $display("FAIL t1_rdata got=%h want=%h", a_m0_rdata, e.d); end
        end
        n_cmp++;
        if (a_m1_rdata !== 32'h0) begin n_err++; $display("FAIL t1_m1_rdata got=%h want=0", a_m1_rdata); end
        step();
        #1;
        n_cmp++;
        if (a_ctl !== 6'b000000) begin n_err++; $display("FAIL t1_after got=%b want=000000", a_ctl); end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  exp_ctl;
        logic [31:0] exp_addr, exp_wdata;
        do_reset();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h20; m0_wdata = 32'h11;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h24; m1_wdata = 32'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_ctl   = (i % 2 == 0) ? 6'b100100 : 6'b010100;
            exp_addr  = (i % 2 == 0) ? 32'h20 : 32'h24;
            exp_wdata = (i % 2 == 0) ? 32'h11 : 32'h22;
            n_cmp++;
            if (a_ctl !== exp_ctl) begin n_err++; $display("FAIL t2_ctl[%0d] got=%b want=%b", i, a_ctl, exp_ctl); end
            n_cmp++;
            if (a_memaddr !== exp_addr || a_memwdata !== exp_wdata) begin
                n_err++; $display("FAIL t2_cmd[%0d] got=%h/%h want=%h/%h", i, a_memaddr, a_memwdata, exp_addr, exp_wdata);
            end
            step();
        end
        clear_reqs();
        n_cmp++;
        if (mem_a[8'h20] !== 32'h11 || mem_a[8'h24] !== 32'h22) begin
            n_err++; $display("FAIL t2_mem got=%h/%h want=00000011/00000022", mem_a[8'h20], mem_a[8'h24]);
        end
    endtask

    task automatic test_rd_wait();
        do_reset();
        preload(8'h30, 32'hC0DE_0030);
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h30;
        #1;
        n_cmp++;
        if (b_ctl !== 6'b011000 || b_memaddr !== 32'h30) begin
            n_err++; $display("FAIL t3_gnt got=%b/%h want=011000/00000030", b_ctl, b_memaddr);
        end
        sb.push_back('{m: 1'b1, d: 32'hC0DE_0030});
        step();
        m1_req = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h40; m0_wdata = 32'h77;
        for (int i = 1; i <= 3; i++) begin
            #1;
            n_cmp++;
            if (b_ctl !== ((i < 3) ? 6'b000000 : 6'b000001)) begin
                n_err++; $display("FAIL t3_wait[%0d] got=%b want=%b", i, b_ctl, (i < 3) ? 6'b000000 : 6'b000001);
            end
            n_cmp++;
            if (b_m0_rdata !== 32'h0 || (i < 3 && b_m1_rdata !== 32'h0)) begin
                n_err++; $display("FAIL t3_rdata_idle[%0d] got=%h/%h want=0", i, b_m0_rdata, b_m1_rdata);
            end
            if (b_m1_rvalid && sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (e.m !== 1'b1 || b_m1_rdata !== e.d) begin n_err++; $display("FAIL t3_rdata got=%h want=%h", b_m1_rdata, e.d); end
            end
            step();
        end
        #1;
        n_cmp++;
        if (b_ctl !== 6'b100100 || b_memaddr !== 32'h40 || b_memwdata !== 32'h77) begin
            n_err++; $display("FAIL t3_next_gnt got=%b/%h/%h want=100100/00000040/00000077", b_ctl, b_memaddr, b_memwdata);
        end
        step();
        clear_reqs();
    endtask

    task automatic test_both_read();
        do_reset();
        preload(8'h10, 32'hA5A5_0001);
        preload(8'h14, 32'h2222_0014);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h14;
        #1;
        n_cmp++;
        if (a_ctl !== 6'b101000 || a_memaddr !== 32'h10) begin
            n_err++; $display("FAIL t4_first got=%b/%h want=101000/00000010", a_ctl, a_memaddr);
        end
        sb.push_back('{m: 1'b0, d: 32'hA5A5_0001});
        step();
        m0_req = 1'b0;
        #1;
        n_cmp++;
        if (a_ctl !== 6'b000010) begin n_err++; $display("FAIL t4_rv0_ctl got=%b want=000010", a_ctl); end
        if (a_m0_rvalid && sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (e.m !== 1'b0 || a_m0_rdata !== e.d) begin n_err++; $display("FAIL t4_rdata0 got=%h want=%h", a_m0_rdata, e.d); end
        end
        step();
        #1;
        n_cmp++;
        if (a_ctl !== 6'b011000 || a_memaddr !== 32'h14) begin
            n_err++; $display("FAIL t4_second got=%b/%h want=011000/00000014", a_ctl, a_memaddr);
        end
        sb.push_back('{m: 1'b1, d: 32'h2222_0014});
        step();
        m1_req = 1'b0;
        #1;
        n_cmp++;
        if (a_ctl !== 6'b000001) begin n_err++; $display("FAIL t4_rv1_ctl got=%b want=000001", a_ctl); end
        if (a_m1_rvalid && sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (e.m !== 1'b1 || a_m1_rdata !== e.d) begin n_err++; $display("FAIL t4_rdata1 got=%h want=%h", a_m1_rdata, e.d); end
        end
        step();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
        #1;
        n_cmp++;
        if (a_ctl !== 6'b101000) begin n_err++; $display("FAIL t5_gnt got=%b want=101000", a_ctl); end
        step();
        m0_req = 1'b0;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (a_ctl !== 6'b000000 || a_m0_rdata !== 32'h0) begin
            n_err++; $display("FAIL t5_dropped got=%b/%h want=000000/0", a_ctl, a_m0_rdata);
        end
        step();
        rst = 1'b1;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h50; m0_wdata = 32'h55;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h54; m1_wdata = 32'h66;
        #1;
        n_cmp++;
        if (a_ctl !== 6'b100100 || a_memaddr !== 32'h50) begin
            n_err++; $display("FAIL t5_conflict got=%b/%h want=100100/00000050", a_ctl, a_memaddr);
        end
        step();
        clear_reqs();
        #1;
        n_cmp++;
        if (a_ctl !== 6'b000000) begin n_err++; $display("FAIL t5_quiet got=%b want=000000", a_ctl); end
    endtask

    task automatic test_contention();
        logic [5:0] exp_ctl;
        do_reset();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h60; m0_wdata = 32'h5;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h64; m1_wdata = 32'h6;
        for (int i = 0; i < 5; i++) begin
            #1;
`ifdef MEM_ARB_FIXED_PRIO_EN
            exp_ctl = 6'b100100;
`else
            exp_ctl = (i % 2 == 0) ? 6'b100100 : 6'b010100;
`endif
            n_cmp++;
            if (a_ctl !== exp_ctl) begin n_err++; $display("FAIL t6_ctl[%0d] got=%b want=%b", i, a_ctl, exp_ctl); end
            n_cmp++;
            if (a_memaddr !== (exp_ctl[5] ? 32'h60 : 32'h64)) begin
                n_err++; $display("FAIL t6_addr[%0d] got=%h want=%h", i, a_memaddr, exp_ctl[5] ? 32'h60 : 32'h64);
            end
            step();
        end
        clear_reqs();
    endtask

    initial begin
        test_reset();
        test_read();
        test_back_to_back();
        test_rd_wait();
        test_both_read();
        test_reset_mid_read();
        test_contention();
        n_cmp++;
        if (sb.size() != 0) begin n_err++; $display("FAIL sb_drained got=%0d want=0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
